// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide unit.
// Covers datapath width, M-extension funct3 codes, FSM encoding and operand signedness helpers.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_signed_a(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic f3_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Request/response bundle between the ID/EX pipeline and the multiply/divide unit.
// master = pipeline/hazard side, slave = ex_mdu.
interface ex_mdu_if;
    import rv32_pkg::*;

    logic            start_i;
    logic            kill_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, kill_i, funct3_i, op_a_i, op_b_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, kill_i, funct3_i, op_a_i, op_b_i,
        output busy_o, stall_o, done_o, result_o
    );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: LSB-first shift-add multiply or restoring divide.
// acc = {hi, lo}; multiply keeps the multiplier in lo, divide keeps {remainder, dividend/quotient}.
module mdu_step
    import rv32_pkg::*;
(
    input  logic              i_mode,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_diff;

    assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
    // Shifted partial remainder needs one extra bit before the trial subtract.
    assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    assign w_diff   = w_rem_sh[XLEN-1:0] - i_operand;

    always_comb begin
        // NOTE: default assignment first so every path drives o_acc and no latch is inferred.
        o_acc = i_acc;
        if (!i_mode) begin
            if (i_acc[0]) o_acc = {w_sum, i_acc[XLEN-1:1]};
            else          o_acc = {1'b0, i_acc[2*XLEN-1:1]};
        end else begin
            if (w_rem_sh >= {1'b0, i_operand}) o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
            else                               o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: fixed 34-cycle latency, stalls the front of the pipe while busy.
// Owns operand capture, the iteration counter, and sign/corner-case fixup of the result.
module ex_mdu
    import rv32_pkg::*;
#(
    parameter int STEPS = XLEN
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_mdu_if.slave  bus
);

    localparam int CW = $clog2(STEPS);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_result;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_div0;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix;

    assign w_accept = bus.start_i & ~bus.kill_i & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_a_neg  = f3_signed_a(bus.funct3_i) & bus.op_a_i[XLEN-1];
    assign w_b_neg  = f3_signed_b(bus.funct3_i) & bus.op_b_i[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.op_a_i : bus.op_a_i;
    assign w_b_mag  = w_b_neg ? -bus.op_b_i : bus.op_b_i;

    mdu_step u_step (
        .i_mode    (f3_is_div(r_funct3)),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_acc_next)
    );

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Divide-by-zero bypasses the sign logic entirely.
    always_comb begin
        w_fix = '0;
        case (r_funct3)
            F3_MUL:                       w_fix = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_fix = r_div0 ? '1 : w_quo;
            default:                      w_fix = r_div0 ? r_op_a : w_rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_op_a    <= '0;
            r_result  <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else if (bus.kill_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(STEPS - 1)) r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    r_result <= w_fix;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (w_accept) begin
                        r_state   <= S_CALC;
                        r_cnt     <= '0;
                        r_funct3  <= bus.funct3_i;
                        r_op_a    <= bus.op_a_i;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_div0    <= (bus.op_b_i == '0);
                        if (f3_is_div(bus.funct3_i)) begin
                            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy_o   = (r_state == S_CALC) | (r_state == S_FIXUP);
    assign bus.done_o   = (r_state == S_DONE);
    assign bus.stall_o  = bus.busy_o | w_accept;
    assign bus.result_o = r_result;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: directed ops push expected results, a monitor pops on done_o.
module tb_ex_mdu;
    import rv32_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_mdu_if bus();

    ex_mdu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'b0, bus.done_o}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, bus.result_o, mon_e.res);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name, input logic [31:0] exp);
        bus.funct3_i = f3;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        if (push) sb_q.push_back('{name, exp});
        @(negedge clk);
        bus.start_i  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done_o === 1'b1) begin
                cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string name, input logic [31:0] exp);
        int cyc;
        @(negedge clk);
        issue(f3, a, b, 1'b1, name, exp);
        wait_done(cyc);
        check({name, "_latency"}, cyc, 32'd34);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  c1, c2;
        bit  busy_ok, done_ok, seen_done;

        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = 3'b000;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        rst_n        = 1'b0;
        #1;
        check("reset_flags", {29'b0, bus.busy_o, bus.done_o, bus.stall_o}, 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // MUL 7*6 with cycle-accurate busy/done/stall checks
        @(negedge clk);
        bus.funct3_i = F3_MUL;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'd6;
        bus.start_i  = 1'b1;
        sb_q.push_back('{"mul_7x6", 32'd42});
        #1;
        check("start_cycle_stall", {31'b0, bus.stall_o}, 32'd1);
        busy_ok = 1'b1;
        done_ok = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            if (bus.busy_o !== (c <= 33)) busy_ok = 1'b0;
            if (bus.done_o !== (c == 34)) done_ok = 1'b0;
        end
        check("mul_busy_window", {31'b0, busy_ok}, 32'd1);
        check("mul_done_at_n34", {31'b0, done_ok}, 32'd1);

        // kill at CALC cnt=10: back to IDLE, no done, result held
        @(negedge clk);
        issue(F3_MUL, 32'd3, 32'd5, 1'b0, "", 32'd0);
        repeat (10) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        check("kill_to_idle", {30'b0, bus.busy_o, bus.done_o}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) seen_done = 1'b1;
        end
        check("kill_no_done", {31'b0, seen_done}, 32'd0);
        check("kill_result_held", bus.result_o, 32'd42);

        // start and kill together: kill wins
        bus.funct3_i = F3_MUL;
        bus.op_a_i   = 32'd2;
        bus.op_b_i   = 32'd2;
        bus.start_i  = 1'b1;
        bus.kill_i   = 1'b1;
        #1;
        check("start_kill_stall", {31'b0, bus.stall_o}, 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("start_kill_idle", {31'b0, bus.busy_o}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) seen_done = 1'b1;
        end
        check("start_kill_no_done", {31'b0, seen_done}, 32'd0);

        run_op(F3_MUL,    32'hFFFF_FFFD, 32'd5,         "mul_neg",     32'hFFFF_FFF1);
        run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1_m1",  32'h0000_0000);
        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max",   32'hFFFF_FFFE);
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         "mulhsu_m1_2", 32'hFFFF_FFFF);
        run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         "div_m7_2",    32'hFFFF_FFFD);
        run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         "rem_m7_2",    32'hFFFF_FFFF);
        run_op(F3_DIVU,   32'd100,       32'd7,         "divu_100_7",  32'd14);
        run_op(F3_REMU,   32'd100,       32'd7,         "remu_100_7",  32'd2);
        run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",     32'h8000_0000);
        run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf",     32'd0);
        run_op(F3_DIVU,   32'd9,         32'd0,         "divu_by0",    32'hFFFF_FFFF);
        run_op(F3_DIV,    32'd5,         32'd0,         "div_by0",     32'hFFFF_FFFF);
        run_op(F3_REM,    32'hFFFF_FFFB, 32'd0,         "rem_neg_by0", 32'hFFFF_FFFB);
        run_op(F3_REM,    32'd5,         32'd0,         "rem_by0",     32'd5);

        // reset mid-CALC clears everything immediately
        @(negedge clk);
        issue(F3_MUL, 32'd9, 32'd9, 1'b0, "", 32'd0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {29'b0, bus.busy_o, bus.done_o, bus.stall_o}, 32'd0);
        check("rst_mid_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: second start issued in the DONE cycle of the first
        @(negedge clk);
        issue(F3_MUL, 32'd12, 32'd12, 1'b1, "b2b_first", 32'd144);
        wait_done(c1);
        check("b2b_first_latency", c1, 32'd34);
        issue(F3_MULHU, 32'h8000_0000, 32'd4, 1'b1, "b2b_second", 32'd2);
        wait_done(c2);
        check("b2b_second_latency", c2, 32'd34);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
